// File: rtl/snes_poll_sequencer_if.sv
// snes_poll_sequencer_if
//   Groups the host-side control/status signals and the pad wires of the
//   SNES poll sequencer into one bundle.
//   master : the sequencer (drives the latch/clock wires and the status outputs)
//   slave  : the host plus pad side (drives enable, poll_now and the data wire)
//   Signals:
//     enable      host -> seq   frame timer runs and launches polls
//     poll_now    host -> seq   single-cycle request for an immediate poll
//     snes_dat    pad  -> seq   serial data, active-low
//     snes_lat    seq  -> pad   latch
//     snes_clk    seq  -> pad   shift clock, idles high
//     data_word   seq  -> host  last captured word, 1 = pressed
//     data_valid  seq  -> host  single-cycle strobe, data_word just updated
//     busy        seq  -> host  poll in progress
//     missed_poll seq  -> host  single-cycle strobe, frame tick dropped while busy
interface snes_poll_sequencer_if #(
  parameter int NUM_BITS = 16
);
  logic                enable;
  logic                poll_now;
  logic                snes_dat;
  logic                snes_lat;
  logic                snes_clk;
  logic [NUM_BITS-1:0] data_word;
  logic                data_valid;
  logic                busy;
  logic                missed_poll;

  modport master (
    input  enable, poll_now, snes_dat,
    output snes_lat, snes_clk, data_word, data_valid, busy, missed_poll
  );

  modport slave (
    output enable, poll_now, snes_dat,
    input  snes_lat, snes_clk, data_word, data_valid, busy, missed_poll
  );
endinterface

// File: rtl/snes_poll_sequencer.sv
// snes_poll_sequencer
//   Console-side SNES pad poller. A free-running frame timer (while enabled)
//   or a poll_now request launches a poll: one latch pulse, a gap, then
//   NUM_BITS clock pulses. The data wire is sampled on the last high cycle
//   before each falling edge of snes_clk, and the captured word is published
//   with a single-cycle data_valid strobe.
//   Ports:
//     sys_clk  system clock
//     sys_rst  synchronous reset, active-high
//     bus      snes_poll_sequencer_if.master (control, pad wires, status)
module snes_poll_sequencer #(
  parameter int FRAME_CYCLES = 800000,
  parameter int LATCH_CYCLES = 576,
  parameter int HALF_CYCLES  = 288,
  parameter int NUM_BITS     = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  snes_poll_sequencer_if.master         bus
);

  localparam int FRAME_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int PH_MAX  = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BIT_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
  localparam logic [PH_W-1:0]    LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
  localparam logic [PH_W-1:0]    HALF_LAST  = PH_W'(HALF_CYCLES - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, GAP, CLK_LOW, CLK_HIGH, DONE
  } state_t;

  state_t              state_reg,   state_next;
  logic [PH_W-1:0]     phase_reg,   phase_next;
  logic [BIT_W-1:0]    bit_idx_reg, bit_idx_next;
  logic [NUM_BITS-1:0] shift_reg,   shift_next;
  logic [NUM_BITS-1:0] word_reg,    word_next;
  logic [FRAME_W-1:0]  frame_cnt_reg;
  logic                frame_tick;

  // Frame timer: held at zero while disabled so enabling always gives a full
  // frame before the first tick. It keeps running during a poll.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !bus.enable) begin
      frame_cnt_reg <= '0;
    end else if (frame_cnt_reg == FRAME_LAST) begin
      frame_cnt_reg <= '0;
    end else begin
      frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
    end
  end

  assign frame_tick = bus.enable && (frame_cnt_reg == FRAME_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg   <= IDLE;
      phase_reg   <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      word_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      word_reg    <= word_next;
    end
  end

  // Bits arrive LSB first, so each sample enters at the MSB and shifts down;
  // after NUM_BITS samples bit 0 sits at the LSB.
  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    word_next    = word_reg;
    case (state_reg)
      IDLE: begin
        phase_next   = '0;
        bit_idx_next = '0;
        if (frame_tick || bus.poll_now) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (phase_reg == LATCH_LAST) begin
          phase_next = '0;
          state_next = GAP;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      GAP: begin
        if (phase_reg == HALF_LAST) begin
          phase_next = '0;
          shift_next = {~bus.snes_dat, shift_reg[NUM_BITS-1:1]};
          state_next = CLK_LOW;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      CLK_LOW: begin
        if (phase_reg == HALF_LAST) begin
          phase_next = '0;
          state_next = CLK_HIGH;
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      CLK_HIGH: begin
        if (phase_reg == HALF_LAST) begin
          phase_next = '0;
          if (bit_idx_reg < BIT_LAST) begin
            bit_idx_next = bit_idx_reg + BIT_W'(1);
            shift_next   = {~bus.snes_dat, shift_reg[NUM_BITS-1:1]};
            state_next   = CLK_LOW;
          end else begin
            // Word is loaded on entry so it is already valid during DONE.
            word_next  = shift_reg;
            state_next = DONE;
          end
        end else begin
          phase_next = phase_reg + PH_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.snes_lat    = (state_reg == LATCH);
  assign bus.snes_clk    = (state_reg != CLK_LOW);
  assign bus.data_word   = word_reg;
  assign bus.data_valid  = (state_reg == DONE);
  assign bus.busy        = (state_reg != IDLE);
  assign bus.missed_poll = frame_tick && (state_reg != IDLE);

endmodule

// File: tb/tb_snes_poll_sequencer.sv
// tb_snes_poll_sequencer
//   Directed bench for snes_poll_sequencer. Two instances: dut_a with a 2000
//   cycle frame and dut_b with a 150 cycle frame (shorter than one poll).
//   Each has a pad model that shifts out a programmable word, and a monitor
//   that checks every data_valid against a scoreboard queue.
module tb_snes_poll_sequencer;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  snes_poll_sequencer_if #(.NUM_BITS(16)) bus_a ();
  snes_poll_sequencer_if #(.NUM_BITS(16)) bus_b ();

  snes_poll_sequencer #(
    .FRAME_CYCLES(2000), .LATCH_CYCLES(12), .HALF_CYCLES(6), .NUM_BITS(16)
  ) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_a)
  );

  snes_poll_sequencer #(
    .FRAME_CYCLES(150), .LATCH_CYCLES(12), .HALF_CYCLES(6), .NUM_BITS(16)
  ) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus_b)
  );

  // Pad models: index cleared while latched, advanced on each snes_clk rise.
  logic [15:0] pad_word_a = 16'h0000;
  logic [15:0] pad_word_b = 16'h0000;
  int          pad_idx_a = 0;
  int          pad_idx_b = 0;
  logic        pad_clk_prev_a = 1'b1;
  logic        pad_clk_prev_b = 1'b1;

  always @(posedge sys_clk) begin
    if (bus_a.snes_lat) pad_idx_a <= 0;
    else if (bus_a.snes_clk && !pad_clk_prev_a) pad_idx_a <= pad_idx_a + 1;
    pad_clk_prev_a <= bus_a.snes_clk;
    if (bus_b.snes_lat) pad_idx_b <= 0;
    else if (bus_b.snes_clk && !pad_clk_prev_b) pad_idx_b <= pad_idx_b + 1;
    pad_clk_prev_b <= bus_b.snes_clk;
  end

  assign bus_a.snes_dat = (pad_idx_a < 16) ? ~pad_word_a[pad_idx_a[3:0]] : 1'b0;
  assign bus_b.snes_dat = (pad_idx_b < 16) ? ~pad_word_b[pad_idx_b[3:0]] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];

  // Monitor A
  int   rise_t_a[$];
  int   lat_len_a = 0, low_cnt_a = 0, low_bad_a = 0, fall_t_a = 0;
  int   missed_cnt_a = 0, valid_cnt_a = 0, valid_t_a = 0;
  logic lat_prev_a = 1'b0, clk_prev_a = 1'b1;

  always @(negedge sys_clk) begin
    if (bus_a.snes_lat && !lat_prev_a) begin
      rise_t_a.push_back(cyc);
      low_cnt_a = 0;
    end
    if (!bus_a.snes_lat && lat_prev_a) lat_len_a = cyc - rise_t_a[$];
    if (!bus_a.snes_clk && clk_prev_a) begin
      low_cnt_a++;
      fall_t_a = cyc;
    end
    if (bus_a.snes_clk && !clk_prev_a && (cyc - fall_t_a) != 6) low_bad_a++;
    if (bus_a.missed_poll) missed_cnt_a++;
    if (bus_a.data_valid) begin
      valid_cnt_a++;
      valid_t_a = cyc;
      $display("txn a word=%h at cycle %0d", bus_a.data_word, cyc);
      check("sb_a_nonempty", (sb_a.size() != 0), 1);
      if (sb_a.size() != 0) check("sb_a_word", bus_a.data_word, sb_a.pop_front());
    end
    lat_prev_a = bus_a.snes_lat;
    clk_prev_a = bus_a.snes_clk;
  end

  // Monitor B
  int   rise_t_b[$];
  int   missed_cnt_b = 0, missed_t_b = 0, valid_cnt_b = 0;
  logic lat_prev_b = 1'b0;

  always @(negedge sys_clk) begin
    if (bus_b.snes_lat && !lat_prev_b) rise_t_b.push_back(cyc);
    if (bus_b.missed_poll) begin
      if (missed_cnt_b == 0) missed_t_b = cyc;
      missed_cnt_b++;
    end
    if (bus_b.data_valid) begin
      valid_cnt_b++;
      $display("txn b word=%h at cycle %0d", bus_b.data_word, cyc);
      check("sb_b_nonempty", (sb_b.size() != 0), 1);
      if (sb_b.size() != 0) check("sb_b_word", bus_b.data_word, sb_b.pop_front());
    end
    lat_prev_b = bus_b.snes_lat;
  end

  logic [15:0] pats [3];
  int          idle_bad;
  int          base_valid, base_rise;

  initial begin
    pats[0] = 16'h0000;
    pats[1] = 16'hFFFF;
    pats[2] = 16'h8001;
    bus_a.enable = 1'b0; bus_a.poll_now = 1'b0;
    bus_b.enable = 1'b0; bus_b.poll_now = 1'b0;

    // 1. reset and idle
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_lat", bus_a.snes_lat, 0);
    check("rst_clk", bus_a.snes_clk, 1);
    check("rst_busy", bus_a.busy, 0);
    check("rst_word", bus_a.data_word, 0);
    check("rst_valid", bus_a.data_valid, 0);
    sys_rst = 1'b0;
    idle_bad = 0;
    repeat (20) begin
      @(negedge sys_clk);
      if (bus_a.snes_lat !== 1'b0 || bus_a.snes_clk !== 1'b1 || bus_a.busy !== 1'b0 ||
          bus_a.data_word !== 16'h0 || bus_a.missed_poll !== 1'b0) idle_bad++;
    end
    check("idle_stable", idle_bad, 0);

    // 2. first frame poll
    pad_word_a = 16'hA5C3;
    sb_a.push_back(16'hA5C3);
    bus_a.enable = 1'b1;
    for (int i = 0; i < 2300 && valid_cnt_a < 1; i++) @(negedge sys_clk);
    check("t2_valid_cnt", valid_cnt_a, 1);
    check("t2_lat_len", lat_len_a, 12);
    check("t2_low_cnt", low_cnt_a, 16);
    check("t2_low_bad", low_bad_a, 0);
    check("t2_latency", valid_t_a - (rise_t_a[0] - 1), 211);

    // 3. free-run three more frames
    for (int f = 0; f < 3; f++) begin
      pad_word_a = pats[f];
      sb_a.push_back(pats[f]);
      for (int i = 0; i < 2300 && valid_cnt_a < 2 + f; i++) @(negedge sys_clk);
    end
    bus_a.enable = 1'b0;
    check("t3_valid_cnt", valid_cnt_a, 4);
    check("t3_rise_cnt", rise_t_a.size(), 4);
    for (int k = 0; k < 3; k++) check("t3_period", rise_t_a[k+1] - rise_t_a[k], 2000);

    // 4. poll_now while idle, second request while busy is ignored
    repeat (50) @(negedge sys_clk);
    pad_word_a = 16'h3C5A;
    sb_a.push_back(16'h3C5A);
    bus_a.poll_now = 1'b1;
    @(negedge sys_clk);
    bus_a.poll_now = 1'b0;
    repeat (50) @(negedge sys_clk);
    check("t4_busy", bus_a.busy, 1);
    bus_a.poll_now = 1'b1;
    @(negedge sys_clk);
    bus_a.poll_now = 1'b0;
    for (int i = 0; i < 400 && valid_cnt_a < 5; i++) @(negedge sys_clk);
    repeat (300) @(negedge sys_clk);
    check("t4_valid_cnt", valid_cnt_a, 5);
    check("t4_rise_cnt", rise_t_a.size(), 5);
    check("t4_missed", missed_cnt_a, 0);
    check("t4_low_bad", low_bad_a, 0);
    check("t4_idle", bus_a.busy, 0);

    // 5. short frame: tick during a poll is dropped
    pad_word_b = 16'h1234;
    sb_b.push_back(16'h1234);
    bus_b.enable = 1'b1;
    for (int i = 0; i < 500 && valid_cnt_b < 1; i++) @(negedge sys_clk);
    pad_word_b = 16'hFEDC;
    sb_b.push_back(16'hFEDC);
    for (int i = 0; i < 200 && rise_t_b.size() < 2; i++) @(negedge sys_clk);
    bus_b.enable = 1'b0;
    for (int i = 0; i < 300 && valid_cnt_b < 2; i++) @(negedge sys_clk);
    check("t5_valid_cnt", valid_cnt_b, 2);
    check("t5_missed_cnt", missed_cnt_b, 1);
    check("t5_missed_t", missed_t_b - rise_t_b[0], 149);
    check("t5_restart_t", rise_t_b[1] - missed_t_b, 151);

    // 6. reset during the fifth low clock phase
    base_valid = valid_cnt_a;
    base_rise  = rise_t_a.size();
    bus_a.poll_now = 1'b1;
    @(negedge sys_clk);
    bus_a.poll_now = 1'b0;
    for (int i = 0; i < 200 && low_cnt_a != 5; i++) @(negedge sys_clk);
    check("t6_reached", low_cnt_a, 5);
    check("t6_in_low", bus_a.snes_clk, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("t6_busy", bus_a.busy, 0);
    check("t6_clk", bus_a.snes_clk, 1);
    check("t6_word", bus_a.data_word, 0);
    repeat (300) @(negedge sys_clk);
    check("t6_no_valid", valid_cnt_a, base_valid);
    check("t6_no_restart", rise_t_a.size(), base_rise + 1);
    check("sb_a_empty", sb_a.size(), 0);
    check("sb_b_empty", sb_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
